// File: rtl/eth_dc_hs_rx.sv
// Receive side of a two-phase req/ack toggle handshake: synchronises the foreign
// request toggle, captures the bundled word and hands it to local logic via valid/ready.
module eth_dc_hs_rx #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_tgl,
   input  logic [DATA_W-1:0] data_in,
   output logic              ack_tgl,
   output logic              evt_valid,
   output logic [DATA_W-1:0] evt_data,
   input  logic              evt_ready,
   output logic [CNT_W-1:0]  evt_cnt,
   output logic              proto_err,
   input  logic              err_clr
);

   typedef enum logic {IDLE, VALID} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_seen_q, req_seen_d;
   logic                   ack_q, ack_d;
   logic                   valid_q, valid_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic                   req_sync;
   logic                   req_new;

   assign req_sync = sync_q[SYNC_STAGES-1];
   assign req_new  = (req_sync != req_seen_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q     <= '0;
         state_q    <= IDLE;
         req_seen_q <= 1'b0;
         ack_q      <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], req_tgl};
         state_q    <= state_d;
         req_seen_q <= req_seen_d;
         ack_q      <= ack_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      req_seen_d = req_seen_q;
      ack_d      = ack_q;
      valid_d    = valid_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      if (err_clr) begin
         err_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (req_new) begin
               data_d     = data_in;
               valid_d    = 1'b1;
               req_seen_d = req_sync;
               state_d    = VALID;
            end
         end
         VALID: begin
            // A fresh toggle here is left uncaptured; IDLE picks up whatever mismatch remains.
            if (req_new) begin
               err_d = 1'b1;
            end
            if (evt_ready) begin
               valid_d = 1'b0;
               ack_d   = ~ack_q;
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ack_tgl   = ack_q;
   assign evt_valid = valid_q;
   assign evt_data  = data_q;
   assign evt_cnt   = cnt_q;
   assign proto_err = err_q;

endmodule

// File: tb/tb_eth_dc_hs_rx.sv
// Directed bench for eth_dc_hs_rx: a 16-bit-counter instance plus a 4-bit-counter
// instance driven by identical stimulus, the latter exercising counter wrap.
module tb_eth_dc_hs_rx;

   logic        clk;
   logic        reset_n;
   logic        req_tgl;
   logic [7:0]  data_in;
   logic        evt_ready;
   logic        err_clr;

   logic        ack_tgl, evt_valid, proto_err;
   logic [7:0]  evt_data;
   logic [15:0] evt_cnt;

   logic        ack4, valid4, err4;
   logic [7:0]  data4;
   logic [3:0]  cnt4;

   int          n_vec;
   int          n_err;
   logic        exp_ack;
   logic [15:0] exp_cnt;

   eth_dc_hs_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(16)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_tgl   (req_tgl),
      .data_in   (data_in),
      .ack_tgl   (ack_tgl),
      .evt_valid (evt_valid),
      .evt_data  (evt_data),
      .evt_ready (evt_ready),
      .evt_cnt   (evt_cnt),
      .proto_err (proto_err),
      .err_clr   (err_clr)
   );

   eth_dc_hs_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(4)) u_dut4 (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_tgl   (req_tgl),
      .data_in   (data_in),
      .ack_tgl   (ack4),
      .evt_valid (valid4),
      .evt_data  (data4),
      .evt_ready (evt_ready),
      .evt_cnt   (cnt4),
      .proto_err (err4),
      .err_clr   (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sender model: toggle request, then wait (bounded) for the acknowledge edge.
   task automatic xfer(input logic [7:0] d);
      logic       done;
      logic [7:0] got_d;
      logic       got_v;
      done  = 1'b0;
      got_v = 1'b0;
      got_d = 8'h00;
      @(negedge clk);
      data_in = d;
      req_tgl = ~req_tgl;
      for (int i = 0; i < 20 && !done; i++) begin
         @(posedge clk);
         #1;
         if (evt_valid && !got_v) begin
            got_v = 1'b1;
            got_d = evt_data;
         end
         if (ack_tgl != exp_ack) done = 1'b1;
      end
      exp_ack = ~exp_ack;
      exp_cnt = exp_cnt + 16'd1;
      chk("xfer_ack_seen", {31'd0, done}, 32'd1);
      chk("xfer_data", {24'd0, got_d}, {24'd0, d});
      chk("xfer_cnt", {16'd0, evt_cnt}, {16'd0, exp_cnt});
      chk("xfer_cnt4", {28'd0, cnt4}, {28'd0, exp_cnt[3:0]});
      $display("xfer data=%02h cnt=%0d cnt4=%0d ack=%0b", got_d, evt_cnt, cnt4, ack_tgl);
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      reset_n   = 1'b0;
      req_tgl   = 1'b0;
      data_in   = 8'h00;
      evt_ready = 1'b0;
      err_clr   = 1'b0;
      exp_ack   = 1'b0;
      exp_cnt   = 16'd0;

      // Reset, then a single word with ready held high
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rst_valid", {31'd0, evt_valid}, 32'd0);
      chk("rst_ack", {31'd0, ack_tgl}, 32'd0);
      chk("rst_cnt", {16'd0, evt_cnt}, 32'd0);
      chk("rst_err", {31'd0, proto_err}, 32'd0);
      chk("rst_data", {24'd0, evt_data}, 32'd0);
      @(negedge clk);
      data_in   = 8'hA5;
      req_tgl   = 1'b1;
      evt_ready = 1'b1;
      edges(2);
      chk("t1_valid_early", {31'd0, evt_valid}, 32'd0);
      edges(1);
      chk("t1_valid", {31'd0, evt_valid}, 32'd1);
      chk("t1_data", {24'd0, evt_data}, 32'hA5);
      edges(1);
      chk("t1_ack", {31'd0, ack_tgl}, 32'd1);
      chk("t1_valid_drop", {31'd0, evt_valid}, 32'd0);
      chk("t1_cnt", {16'd0, evt_cnt}, 32'd1);
      exp_ack = 1'b1;
      exp_cnt = 16'd1;
      $display("single word data=A5 cnt=%0d ack=%0b", evt_cnt, ack_tgl);

      // Backpressure: ten cycles of ready low must freeze everything
      @(negedge clk);
      evt_ready = 1'b0;
      data_in   = 8'h5A;
      req_tgl   = 1'b0;
      edges(3);
      chk("bp_valid", {31'd0, evt_valid}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         edges(1);
         chk("bp_hold_valid", {31'd0, evt_valid}, 32'd1);
         chk("bp_hold_data", {24'd0, evt_data}, 32'h5A);
         chk("bp_hold_ack", {31'd0, ack_tgl}, 32'd1);
      end
      @(negedge clk);
      evt_ready = 1'b1;
      edges(1);
      chk("bp_ack", {31'd0, ack_tgl}, 32'd0);
      chk("bp_valid_drop", {31'd0, evt_valid}, 32'd0);
      chk("bp_cnt", {16'd0, evt_cnt}, 32'd2);
      exp_ack = 1'b0;
      exp_cnt = 16'd2;
      $display("backpressure data=5A cnt=%0d ack=%0b", evt_cnt, ack_tgl);

      // Back-to-back: 16 words from the sender model
      for (int i = 1; i <= 16; i++) xfer(8'(i));
      chk("b2b_cnt", {16'd0, evt_cnt}, 32'd18);
      chk("b2b_ack", {31'd0, ack_tgl}, 32'd0);
      chk("b2b_err", {31'd0, proto_err}, 32'd0);

      // Protocol violation while a word is pending
      @(negedge clk);
      evt_ready = 1'b0;
      data_in   = 8'h77;
      req_tgl   = 1'b1;
      edges(3);
      chk("pv_valid", {31'd0, evt_valid}, 32'd1);
      chk("pv_data", {24'd0, evt_data}, 32'h77);
      @(negedge clk);
      data_in = 8'h3C;
      req_tgl = 1'b0;
      edges(3);
      chk("pv_err", {31'd0, proto_err}, 32'd1);
      chk("pv_data_frozen", {24'd0, evt_data}, 32'h77);
      chk("pv_ack_held", {31'd0, ack_tgl}, 32'd0);
      @(negedge clk);
      evt_ready = 1'b1;
      edges(1);
      chk("pv_accept_valid", {31'd0, evt_valid}, 32'd0);
      chk("pv_accept_ack", {31'd0, ack_tgl}, 32'd1);
      chk("pv_accept_cnt", {16'd0, evt_cnt}, 32'd19);
      @(negedge clk);
      evt_ready = 1'b0;
      edges(1);
      chk("pv_recap_valid", {31'd0, evt_valid}, 32'd1);
      chk("pv_recap_data", {24'd0, evt_data}, 32'h3C);
      $display("violation: recaptured data=%02h err=%0b", evt_data, proto_err);
      @(negedge clk);
      err_clr = 1'b1;
      edges(1);
      chk("pv_clr", {31'd0, proto_err}, 32'd0);
      @(negedge clk);
      err_clr = 1'b0;
      data_in = 8'h99;
      req_tgl = 1'b1;
      edges(2);
      @(negedge clk);
      err_clr = 1'b1;
      edges(1);
      chk("pv_set_wins", {31'd0, proto_err}, 32'd1);
      chk("pv_data_frozen2", {24'd0, evt_data}, 32'h3C);
      @(negedge clk);
      err_clr = 1'b0;
      edges(1);
      chk("pv_sticky", {31'd0, proto_err}, 32'd1);
      @(negedge clk);
      evt_ready = 1'b1;
      edges(2);
      chk("pv_next_valid", {31'd0, evt_valid}, 32'd1);
      chk("pv_next_data", {24'd0, evt_data}, 32'h99);
      edges(1);
      chk("pv_final_ack", {31'd0, ack_tgl}, 32'd1);
      chk("pv_final_cnt", {16'd0, evt_cnt}, 32'd21);
      chk("pv_final_valid", {31'd0, evt_valid}, 32'd0);
      $display("violation: set-over-clear err=%0b cnt=%0d", proto_err, evt_cnt);

      // Asynchronous reset while a word is pending
      @(negedge clk);
      evt_ready = 1'b0;
      data_in   = 8'h42;
      req_tgl   = 1'b0;
      edges(3);
      chk("ar_valid_pre", {31'd0, evt_valid}, 32'd1);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      req_tgl = 1'b0;
      #1;
      chk("ar_valid", {31'd0, evt_valid}, 32'd0);
      chk("ar_ack", {31'd0, ack_tgl}, 32'd0);
      chk("ar_cnt", {16'd0, evt_cnt}, 32'd0);
      chk("ar_err", {31'd0, proto_err}, 32'd0);
      $display("async reset: valid=%0b ack=%0b cnt=%0d", evt_valid, ack_tgl, evt_cnt);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      exp_ack = 1'b0;
      exp_cnt = 16'd0;
      for (int i = 0; i < 6; i++) begin
         edges(1);
         chk("ar_no_spurious", {31'd0, evt_valid}, 32'd0);
      end

      // Counter wrap on the 4-bit instance: 17 words
      @(negedge clk);
      evt_ready = 1'b1;
      for (int i = 0; i < 17; i++) xfer(8'(8'hC0 + i));
      chk("wrap_cnt4", {28'd0, cnt4}, 32'd1);
      chk("wrap_cnt", {16'd0, evt_cnt}, 32'd17);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
